// File: rtl/d_drain_arbiter.sv
// Drain arbiter: pops destination FIFOs D0/D1, absorbs their read latency and presents one
// registered valid/ready stream with per-channel delivered-word counters.
// Optional: define DRAIN_STRICT_PRIO_EN for strict D0 priority instead of round-robin.
module d_drain_arbiter #(
    parameter int unsigned DATA_SIZE = 6,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 fifo_empty_d0,
    input  logic                 fifo_empty_d1,
    input  logic [DATA_SIZE-1:0] data_out_0_cond,
    input  logic [DATA_SIZE-1:0] data_out_1_cond,
    output logic                 pop_d0,
    output logic                 pop_d1,
    input  logic                 out_ready,
    output logic                 valid_out,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 chan_out,
    output logic [CNT_W-1:0]     count_d0,
    output logic [CNT_W-1:0]     count_d1
);

    typedef enum logic [0:0] {StIdle, StWait} state_t;

    state_t state_q;
    logic   last_q;
    logic   sel_q;
    logic   slot_free;
    logic   any_ready;
    logic   pick;
    logic   pop_any;
    logic   transfer;

    always_comb begin
        // The slot must be free at the pop edge so a capture never collides with a held word.
        slot_free = !valid_out || out_ready;
        any_ready = !fifo_empty_d0 || !fifo_empty_d1;
`ifdef DRAIN_STRICT_PRIO_EN
        pick = fifo_empty_d0;
`else
        if (!fifo_empty_d0 && !fifo_empty_d1) begin
            pick = !last_q;
        end else begin
            pick = fifo_empty_d0;
        end
`endif
        pop_any  = reset_L && (state_q == StIdle) && slot_free && any_ready;
        pop_d0   = pop_any && !pick;
        pop_d1   = pop_any && pick;
        transfer = valid_out && out_ready;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            sel_q     <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            chan_out  <= 1'b0;
            count_d0  <= '0;
            count_d1  <= '0;
        end else begin
            if (transfer) begin
                valid_out <= 1'b0;
                if (chan_out) begin
                    count_d1 <= count_d1 + CNT_W'(1);
                end else begin
                    count_d0 <= count_d0 + CNT_W'(1);
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (pop_any) begin
                        state_q <= StWait;
                        sel_q   <= pick;
                        last_q  <= pick;
                    end
                end
                StWait: begin
                    state_q   <= StIdle;
                    data_out  <= sel_q ? data_out_1_cond : data_out_0_cond;
                    chan_out  <= sel_q;
                    valid_out <= 1'b1;
                end
            endcase
        end
    end

    pop_onehot_a: assert property (@(posedge clk) disable iff (!reset_L)
        !(pop_d0 && pop_d1));
    no_pop_in_wait_a: assert property (@(posedge clk) disable iff (!reset_L)
        (state_q == StWait) |-> (!pop_d0 && !pop_d1));

endmodule

// File: tb/tb_d_drain_arbiter.sv
// Bench for d_drain_arbiter: queue-based D FIFO models and a transaction-level scoreboard.
module tb_d_drain_arbiter;
    localparam int DW = 6;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_L;
    logic          fifo_empty_d0, fifo_empty_d1, out_ready;
    logic [DW-1:0] data_out_0_cond, data_out_1_cond;
    logic          pop_d0, pop_d1, valid_out, chan_out;
    logic [DW-1:0] data_out;
    logic [CW-1:0] count_d0, count_d1;
    logic          s_pop_d0, s_pop_d1, s_valid_out, s_chan_out;
    logic [DW-1:0] s_data_out;
    logic [1:0]    s_count_d0, s_count_d1;

    d_drain_arbiter #(.DATA_SIZE(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset_L(reset_L), .fifo_empty_d0(fifo_empty_d0),
        .fifo_empty_d1(fifo_empty_d1), .data_out_0_cond(data_out_0_cond),
        .data_out_1_cond(data_out_1_cond), .pop_d0(pop_d0), .pop_d1(pop_d1),
        .out_ready(out_ready), .valid_out(valid_out), .data_out(data_out),
        .chan_out(chan_out), .count_d0(count_d0), .count_d1(count_d1)
    );

    // Narrow-counter instance sharing all inputs, for wrap checking.
    d_drain_arbiter #(.DATA_SIZE(DW), .CNT_W(2)) dut_small (
        .clk(clk), .reset_L(reset_L), .fifo_empty_d0(fifo_empty_d0),
        .fifo_empty_d1(fifo_empty_d1), .data_out_0_cond(data_out_0_cond),
        .data_out_1_cond(data_out_1_cond), .pop_d0(s_pop_d0), .pop_d1(s_pop_d1),
        .out_ready(out_ready), .valid_out(s_valid_out), .data_out(s_data_out),
        .chan_out(s_chan_out), .count_d0(s_count_d0), .count_d1(s_count_d1)
    );

    typedef struct {
        bit            ch;
        logic [DW-1:0] d;
    } word_t;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    word_t         expq[$];
    word_t         xfer_w[$];
    int            xfer_cyc[$];
    int            pop_cyc[$];
    bit            m_inflight, m_valid, m_last;
    int            m_cnt0, m_cnt1;
    int            cycle;
    int            checks = 0;
    int            fails = 0;

    task automatic push0(input logic [DW-1:0] d);
        q0.push_back(d);
        fifo_empty_d0 = 1'b0;
    endtask

    task automatic push1(input logic [DW-1:0] d);
        q1.push_back(d);
        fifo_empty_d1 = 1'b0;
    endtask

    task automatic apply_reset();
        reset_L = 1'b0;
        out_ready = 1'b0;
        q0.delete();
        q1.delete();
        fifo_empty_d0 = 1'b1;
        fifo_empty_d1 = 1'b1;
        data_out_0_cond = '0;
        data_out_1_cond = '0;
        m_inflight = 0;
        m_valid = 0;
        m_last = 1;
        m_cnt0 = 0;
        m_cnt1 = 0;
        expq.delete();
        xfer_w.delete();
        xfer_cyc.delete();
        pop_cyc.delete();
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        cycle = 0;
    endtask

    // One clock cycle: predict pop/transfer from the scoreboard, compare, then advance the FIFOs.
    task automatic step(input bit rdy);
        bit    want, ch, xfer, p0, p1;
        word_t w, nw;
        out_ready = rdy;
        #1;
        want = !m_inflight && (!m_valid || rdy) && (q0.size() > 0 || q1.size() > 0);
`ifdef DRAIN_STRICT_PRIO_EN
        ch = (q0.size() == 0);
`else
        if (q0.size() > 0 && q1.size() > 0) ch = !m_last;
        else ch = (q0.size() == 0);
`endif
        checks++;
        if (pop_d0 !== (want && !ch) || pop_d1 !== (want && ch) ||
            s_pop_d0 !== (want && !ch) || s_pop_d1 !== (want && ch)) begin
            fails++;
            $display("FAIL pop cyc=%0d: got d0=%b d1=%b, want d0=%b d1=%b",
                     cycle, pop_d0, pop_d1, want && !ch, want && ch);
        end
        checks++;
        if (valid_out !== m_valid) begin
            fails++;
            $display("FAIL valid cyc=%0d: got %b want %b", cycle, valid_out, m_valid);
        end
        xfer = m_valid && rdy;
        if (xfer) begin
            w = expq.pop_front();
            checks++;
            if (data_out !== w.d || chan_out !== w.ch) begin
                fails++;
                $display("FAIL xfer cyc=%0d: got data=%h chan=%b want data=%h chan=%b",
                         cycle, data_out, chan_out, w.d, w.ch);
            end
            xfer_cyc.push_back(cycle);
            xfer_w.push_back(w);
            if (w.ch) m_cnt1++;
            else m_cnt0++;
        end
        if (want) begin
            pop_cyc.push_back(cycle);
            nw.ch = ch;
            nw.d  = ch ? q1[0] : q0[0];
        end
        p0 = pop_d0;
        p1 = pop_d1;
        @(posedge clk);
        #1;
        if (p0 && q0.size() > 0) data_out_0_cond = q0.pop_front();
        if (p1 && q1.size() > 0) data_out_1_cond = q1.pop_front();
        fifo_empty_d0 = (q0.size() == 0);
        fifo_empty_d1 = (q1.size() == 0);
        if (xfer) m_valid = 0;
        if (m_inflight) begin
            m_valid = 1;
            m_inflight = 0;
        end
        if (want) begin
            m_inflight = 1;
            m_last = ch;
            expq.push_back(nw);
        end
        checks++;
        if (count_d0 !== CW'(m_cnt0) || count_d1 !== CW'(m_cnt1) ||
            s_count_d0 !== 2'(m_cnt0) || s_count_d1 !== 2'(m_cnt1)) begin
            fails++;
            $display("FAIL counts cyc=%0d: got %0d/%0d small %0d/%0d want %0d/%0d",
                     cycle, count_d0, count_d1, s_count_d0, s_count_d1, m_cnt0, m_cnt1);
        end
        @(negedge clk);
        cycle++;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== '0 || chan_out !== 1'b0 || count_d0 !== '0 ||
            count_d1 !== '0 || pop_d0 !== 1'b0 || pop_d1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: got v=%b d=%h c=%b n0=%0d n1=%0d, want all 0",
                     valid_out, data_out, chan_out, count_d0, count_d1);
        end
        for (int i = 1; i <= 4; i++) push0(DW'(i));
        for (int i = 0; i < 5; i++) step(1'b1);
        // Now in WAIT with two words delivered and a third in flight.
        reset_L = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== '0 || chan_out !== 1'b0 || count_d0 !== '0 ||
            count_d1 !== '0 || pop_d0 !== 1'b0 || pop_d1 !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got v=%b d=%h n0=%0d pop=%b%b, want all 0",
                     valid_out, data_out, count_d0, pop_d0, pop_d1);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            checks++;
            if (pop_d0 !== 1'b0 || pop_d1 !== 1'b0 || valid_out !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: got pop=%b%b v=%b want 0", pop_d0, pop_d1, valid_out);
            end
        end
        @(negedge clk);
        apply_reset();
        push1(6'h15);
        for (int i = 0; i < 4; i++) step(1'b1);
    endtask

    task automatic test_single_channel();
        apply_reset();
        push0(6'h01);
        push0(6'h02);
        push0(6'h03);
        for (int i = 0; i < 8; i++) step(1'b1);
        checks++;
        if (pop_cyc.size() != 3 || pop_cyc[0] != 0 || pop_cyc[1] != 2 || pop_cyc[2] != 4) begin
            fails++;
            $display("FAIL single_pops: got %0d pops, want at cycles 0,2,4", pop_cyc.size());
        end
        checks++;
        if (xfer_cyc.size() != 3 || xfer_cyc[0] != 2 || xfer_cyc[1] != 4 || xfer_cyc[2] != 6 ||
            xfer_w[0].d != 6'h01 || xfer_w[1].d != 6'h02 || xfer_w[2].d != 6'h03) begin
            fails++;
            $display("FAIL single_xfers: got %0d transfers, want 01,02,03 at 2,4,6",
                     xfer_cyc.size());
        end
        checks++;
        if (count_d0 !== 8'd3 || count_d1 !== 8'd0) begin
            fails++;
            $display("FAIL single_count: got %0d/%0d want 3/0", count_d0, count_d1);
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] ed[4];
        bit            ec[4];
`ifdef DRAIN_STRICT_PRIO_EN
        ed = '{6'h0A, 6'h0B, 6'h2A, 6'h2B};
        ec = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        ed = '{6'h0A, 6'h2A, 6'h0B, 6'h2B};
        ec = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        apply_reset();
        push0(6'h0A);
        push0(6'h0B);
        push1(6'h2A);
        push1(6'h2B);
        for (int i = 0; i < 10; i++) step(1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (xfer_w.size() != 4 || xfer_w[i].d !== ed[i] || xfer_w[i].ch !== ec[i]) begin
                fails++;
                $display("FAIL order[%0d]: got %h(%b) want %h(%b)",
                         i, xfer_w[i].d, xfer_w[i].ch, ed[i], ec[i]);
            end
        end
        checks++;
        if (count_d0 !== 8'd2 || count_d1 !== 8'd2) begin
            fails++;
            $display("FAIL rr_count: got %0d/%0d want 2/2", count_d0, count_d1);
        end
    endtask

`ifdef DRAIN_STRICT_PRIO_EN
    task automatic test_strict_prio();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            push0(DW'(i + 1));
            push1(DW'(i + 33));
        end
        for (int i = 0; i < 14; i++) step(1'b1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (xfer_w.size() != 6 || xfer_w[i].ch !== (i >= 3)) begin
                fails++;
                $display("FAIL strict[%0d]: got chan %b want %b", i, xfer_w[i].ch, i >= 3);
            end
        end
    endtask
`endif

    task automatic test_backpressure();
        logic [DW-1:0] held;
        int            n = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) push0(DW'(i + 17));
        while (!valid_out && n < 10) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (valid_out !== 1'b1) begin
            fails++;
            $display("FAIL bp_valid: got %b want 1 within 10 cycles", valid_out);
        end
        held = data_out;
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            checks++;
            if (data_out !== held || valid_out !== 1'b1 || pop_d0 !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold: got d=%h v=%b pop=%b want d=%h v=1 pop=0",
                         data_out, valid_out, pop_d0, held);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (!(valid_out === 1'b1 && pop_d0 === 1'b1)) begin
            fails++;
            $display("FAIL bp_release: got v=%b pop=%b want 1/1", valid_out, pop_d0);
        end
        for (int i = 0; i < 12; i++) step(1'($urandom_range(0, 1)));
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        for (int i = 0; i < 5; i++) push1(DW'(i + 40));
        for (int i = 0; i < 12; i++) step(1'b1);
        checks++;
        if (s_count_d1 !== 2'd1 || count_d1 !== 8'd5) begin
            fails++;
            $display("FAIL wrap: got small=%0d wide=%0d want 1/5", s_count_d1, count_d1);
        end
    endtask

    task automatic test_random();
        int tot = 0;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 8) begin
                push0(DW'($urandom));
                tot++;
            end
            if ($urandom_range(0, 2) == 0 && q1.size() < 8) begin
                push1(DW'($urandom));
                tot++;
            end
            step($urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 40; i++) step(1'b1);
        checks++;
        if (m_cnt0 + m_cnt1 != tot || expq.size() != 0 || valid_out !== 1'b0) begin
            fails++;
            $display("FAIL random_drain: got %0d delivered want %0d", m_cnt0 + m_cnt1, tot);
        end
    endtask

    initial begin
        reset_L = 1'b0;
        out_ready = 1'b0;
        fifo_empty_d0 = 1'b1;
        fifo_empty_d1 = 1'b1;
        data_out_0_cond = '0;
        data_out_1_cond = '0;
        @(negedge clk);
        test_reset();
        test_single_channel();
        test_round_robin();
`ifdef DRAIN_STRICT_PRIO_EN
        test_strict_prio();
`endif
        test_backpressure();
        test_counter_wrap();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
